drive_ctrl: RTL

Per-frame player drive controller for MonacoGP. It sits directly upstream of the track scroller and turns raw keyboard keycodes into a registered speed value (0–7) that the scroller adds to its scroll accumulator each frame. It also produces the player car's horizontal position, an odometer, and the game state. A crash input from the collision logic forces a timed crash lockout.

---
 rtl/drive_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/drive_ctrl.sv
// MonacoGP per-frame drive controller: turns keycodes into speed, car position,
// odometer and game state, with a timed lockout after a collision.
module drive_ctrl #(
  parameter int          ACCEL_FRAMES = 8,
  parameter int          BRAKE_FRAMES = 4,
  parameter int          COAST_FRAMES = 32,
  parameter int          CRASH_FRAMES = 60,
  parameter logic [9:0]  X_MIN        = 10'd160,
  parameter logic [9:0]  X_MAX        = 10'd464,
  parameter logic [9:0]  X_START      = 10'd304,
  parameter int          STEER_STEP   = 2
) (
  input  logic        frame_clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  input  logic        crash,
  output logic [2:0]  speed,
  output logic [9:0]  car_x,
  output logic [1:0]  state,
  output logic [15:0] distance
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam logic [7:0] KEY_ACCEL = 8'h1A;
  localparam logic [7:0] KEY_BRAKE = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  localparam logic [7:0] ACCEL_LAST = 8'(ACCEL_FRAMES - 1);
  localparam logic [7:0] BRAKE_LAST = 8'(BRAKE_FRAMES - 1);
  localparam logic [7:0] COAST_LAST = 8'(COAST_FRAMES - 1);
  localparam logic [7:0] CRASH_LAST = 8'(CRASH_FRAMES - 1);
  localparam logic [9:0] STEP_W     = 10'(STEER_STEP);

  state_e      state_q, state_d;
  logic [2:0]  speed_q, speed_d;
  logic [9:0]  car_x_q, car_x_d;
  logic [15:0] dist_q, dist_d;
  logic [7:0]  prev_key_q, prev_key_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  crash_cnt_q, crash_cnt_d;

  logic        key_same_s;
  logic        counting_s;
  logic [7:0]  hold_last_s;
  logic [16:0] dist_sum_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      speed_q     <= 3'd0;
      car_x_q     <= X_START;
      dist_q      <= 16'd0;
      prev_key_q  <= 8'h00;
      hold_cnt_q  <= 8'd0;
      crash_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      car_x_q     <= car_x_d;
      dist_q      <= dist_d;
      prev_key_q  <= prev_key_d;
      hold_cnt_q  <= hold_cnt_d;
      crash_cnt_q <= crash_cnt_d;
    end
  end

  // Hold-length threshold for the keys that step speed
  always_comb begin
    hold_last_s = 8'd0;
    counting_s  = 1'b0;
    case (keycode)
      KEY_ACCEL: begin hold_last_s = ACCEL_LAST; counting_s = 1'b1; end
      KEY_BRAKE: begin hold_last_s = BRAKE_LAST; counting_s = 1'b1; end
      KEY_NONE:  begin hold_last_s = COAST_LAST; counting_s = 1'b1; end
      default:   begin hold_last_s = 8'd0;       counting_s = 1'b0; end
    endcase
  end

  assign key_same_s = (keycode == prev_key_q);
  assign dist_sum_s = {1'b0, dist_q} + {14'd0, speed_q};

  // Next-state and datapath update for the game FSM
  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    car_x_d     = car_x_q;
    dist_d      = dist_q;
    prev_key_d  = keycode;
    hold_cnt_d  = hold_cnt_q;
    crash_cnt_d = crash_cnt_q;

    case (state_q)
      ST_IDLE: begin
        speed_d = 3'd0;
        if (keycode == KEY_ACCEL) begin
          state_d    = ST_RUN;
          hold_cnt_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (crash) begin
          // Collision pre-empts every key action and the odometer this frame
          state_d     = ST_CRASH;
          speed_d     = 3'd0;
          crash_cnt_d = CRASH_LAST;
        end else begin
          dist_d     = dist_sum_s[16] ? 16'hFFFF : dist_sum_s[15:0];
          hold_cnt_d = 8'd0;
          if (key_same_s && counting_s) begin
            if (hold_cnt_q == hold_last_s) begin
              if (keycode == KEY_ACCEL) begin
                speed_d = (speed_q == 3'd7) ? 3'd7 : speed_q + 3'd1;
              end else begin
                speed_d = (speed_q == 3'd0) ? 3'd0 : speed_q - 3'd1;
              end
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end else begin
            hold_cnt_d = 8'd0;
          end

          if (keycode == KEY_LEFT && speed_q != 3'd0) begin
            car_x_d = (car_x_q <= X_MIN + STEP_W) ? X_MIN : car_x_q - STEP_W;
          end else if (keycode == KEY_RIGHT && speed_q != 3'd0) begin
            car_x_d = (car_x_q + STEP_W >= X_MAX) ? X_MAX : car_x_q + STEP_W;
          end else begin
            car_x_d = car_x_q;
          end
        end
      end

      ST_CRASH: begin
        speed_d = 3'd0;
        if (crash_cnt_q == 8'd0) begin
          state_d    = ST_RUN;
          car_x_d    = X_START;
          hold_cnt_d = 8'd0;
        end else begin
          crash_cnt_d = crash_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        speed_d = 3'd0;
      end
    endcase
  end

  assign state    = state_q;
  assign speed    = speed_q;
  assign car_x    = car_x_q;
  assign distance = dist_q;

endmodule
